apb_slave_regfile: RTL

- APB slave register bank; sits directly downstream of the AXI4-Lite-to-APB bridge and terminates its m_apb_* transfers.
- Provides an ID register, a transfer counter, and a bank of byte-strobed RW control registers exported to user logic.
- Inserts a programmable number of wait states and signals PSLVERR for illegal accesses.

---
 rtl/apb_slave_regfile.sv | 138 +++++++++++++
 1 files changed

// File: rtl/apb_slave_regfile.sv
// APB slave register bank: ID, transfer counter and byte-strobed RW control registers,
// with programmable wait states and PSLVERR on illegal accesses.
module apb_slave_regfile #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001,
  parameter bit          PROTECT_EN  = 1'b1
) (
  input  logic                     s_apb_pclk,
  input  logic                     s_apb_preset,
  input  logic [ADDR_WIDTH-1:0]    s_apb_paddr,
  input  logic                     s_apb_psel,
  input  logic                     s_apb_penable,
  input  logic                     s_apb_pwrite,
  input  logic [31:0]              s_apb_pwdata,
  input  logic [3:0]               s_apb_pstrb,
  input  logic [2:0]               s_apb_pprot,
  output logic [31:0]              s_apb_prdata,
  output logic                     s_apb_pready,
  output logic                     s_apb_pslverr,
  output logic [32*NUM_REGS-1:0]   ctrl_out
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [31:0]           wdata_q;
  logic [3:0]            strb_q;
  logic                  priv_q;
  logic [3:0]            wait_q;
  logic [31:0]           xfer_cnt_q;
  logic [31:0]           ctrl_q [2:NUM_REGS-1];

  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      idx;
  logic                  err;
  logic                  commit;
  logic                  wr_en;
  logic [31:0]           rd_word;
  logic                  unused_prot;

  assign unused_prot = ^s_apb_pprot[2:1];

  always_ff @(posedge s_apb_pclk) begin
    if (s_apb_preset) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (s_apb_psel && !s_apb_penable) state_d = ACCESS;
      ACCESS: if (!s_apb_psel || (s_apb_penable && s_apb_pready)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_apb_pready = (state_q == ACCESS) && (wait_q == '0);
  end

  // Decode works on the captured setup-phase values, never on the live bus.
  always_comb begin
    offset = addr_q - ADDR_WIDTH'(BASE_ADDR);
    idx    = offset[IDX_W+1:2];
    err    = (addr_q[1:0] != 2'b00)
          || (addr_q < ADDR_WIDTH'(BASE_ADDR))
          || ((offset >> 2) >= ADDR_WIDTH'(NUM_REGS))
          || (write_q && (idx < IDX_W'(2)))
          || (PROTECT_EN && write_q && !priv_q);
    commit = (state_q == ACCESS) && s_apb_psel && s_apb_penable && s_apb_pready;
    wr_en  = commit && write_q && !err;
  end

  always_comb begin
    rd_word = '0;
    if (idx == IDX_W'(0)) rd_word = ID_VALUE;
    if (idx == IDX_W'(1)) rd_word = xfer_cnt_q;
    for (int unsigned i = 2; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) rd_word = ctrl_q[i];
    end
    s_apb_prdata  = (s_apb_pready && !write_q && !err) ? rd_word : '0;
    s_apb_pslverr = s_apb_pready && err;
  end

  always_ff @(posedge s_apb_pclk) begin
    if (s_apb_preset) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      priv_q  <= 1'b0;
      wait_q  <= '0;
    end else if (state_q == IDLE) begin
      if (s_apb_psel && !s_apb_penable) begin
        addr_q  <= s_apb_paddr;
        write_q <= s_apb_pwrite;
        wdata_q <= s_apb_pwdata;
        strb_q  <= s_apb_pstrb;
        priv_q  <= s_apb_pprot[0];
        wait_q  <= 4'(WAIT_CYCLES);
      end
    end else if (wait_q != '0) begin
      wait_q <= wait_q - 4'd1;
    end
  end

  always_ff @(posedge s_apb_pclk) begin
    if (s_apb_preset) xfer_cnt_q <= '0;
    else if (commit)  xfer_cnt_q <= xfer_cnt_q + 32'd1;
  end

  always_ff @(posedge s_apb_pclk) begin
    if (s_apb_preset) begin
      for (int unsigned i = 2; i < NUM_REGS; i++) ctrl_q[i] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 2; i < NUM_REGS; i++) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if ((idx == IDX_W'(i)) && strb_q[b]) ctrl_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    ctrl_out        = '0;
    ctrl_out[31:0]  = ID_VALUE;
    ctrl_out[63:32] = xfer_cnt_q;
    for (int unsigned i = 2; i < NUM_REGS; i++) ctrl_out[32*i +: 32] = ctrl_q[i];
  end

endmodule
